// File: rtl/image_window_feeder.sv
// Frame buffer plus 5x5 sliding-window generator for the simpleCNN convolution stage.
// Define FRAME_ERR_EN to add the PIX_LAST input and the ERR framing-error pulse.
module image_window_feeder #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int K     = 5,
  parameter int PIX_W = 8
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic                   PIX_VALID,
  output logic                   PIX_READY,
  input  logic [PIX_W-1:0]       PIX_DATA,
`ifdef FRAME_ERR_EN
  input  logic                   PIX_LAST,
`endif
  output logic                   WIN_VALID,
  input  logic                   WIN_READY,
  output logic [4:0]             WIN_X,
  output logic [4:0]             WIN_Y,
  output logic [K*K*PIX_W-1:0]   WIN_DATA,
  output logic                   WIN_LAST,
  output logic                   FRAME_DONE
`ifdef FRAME_ERR_EN
  ,
  output logic                   ERR
`endif
);

  localparam int NPIX = IMG_W * IMG_H;
  localparam int AW   = $clog2(NPIX);
  localparam int WW   = K * K * PIX_W;
  localparam logic [AW-1:0] LAST_ADDR = AW'(NPIX - 1);
  localparam logic [4:0]    X_MAX     = 5'(IMG_W - K);
  localparam logic [4:0]    Y_MAX     = 5'(IMG_H - K);

  typedef enum logic [1:0] {LOAD, SCAN, FIN} state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     wr_cnt_q, wr_cnt_d;
  logic [4:0]        sx_q, sx_d, sy_q, sy_d;
  logic              scan_done_q, scan_done_d;
  logic              win_valid_q, win_valid_d;
  logic              win_last_q, win_last_d;
  logic [4:0]        win_x_q, win_x_d, win_y_q, win_y_d;
  logic [WW-1:0]     win_data_q, win_data_d;
  logic              frame_done_q, frame_done_d;
  logic              err_q, err_d;

  logic [PIX_W-1:0]  mem_q [NPIX];
  logic              accept;
  logic              frame_end;
  logic              bad_frame;
  logic              load_en;
  logic [AW-1:0]     rd_base;
  logic [WW-1:0]     gather;

  assign accept  = (state_q == LOAD) && PIX_VALID;
  assign rd_base = AW'(sy_q * IMG_W) + AW'(sx_q);

  // NOTE: the frame buffer is deliberately left out of reset; every cell is
  // rewritten by a complete frame before SCAN reads it, so clearing it buys nothing.
  always_ff @(posedge CLK) begin
    if (accept) mem_q[wr_cnt_q] <= PIX_DATA;
  end

  // The KxK window anchored at (sx_q, sy_q); byte i*K+j is row i, column j.
  always_comb begin
    gather = '0;
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K; j++) begin
        gather[(i*K+j)*PIX_W +: PIX_W] = mem_q[rd_base + AW'(i*IMG_W + j)];
      end
    end
  end

  // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    wr_cnt_d     = wr_cnt_q;
    sx_d         = sx_q;
    sy_d         = sy_q;
    scan_done_d  = scan_done_q;
    win_valid_d  = win_valid_q;
    win_last_d   = win_last_q;
    win_x_d      = win_x_q;
    win_y_d      = win_y_q;
    win_data_d   = win_data_q;
    frame_done_d = 1'b0;
    err_d        = 1'b0;
    frame_end    = (wr_cnt_q == LAST_ADDR);
    bad_frame    = 1'b0;
    load_en      = !win_valid_q || WIN_READY;
`ifdef FRAME_ERR_EN
    bad_frame    = accept && (PIX_LAST != frame_end);
`endif

    case (state_q)
      LOAD: begin
        if (bad_frame) begin
          err_d    = 1'b1;
          wr_cnt_d = '0;
        end else if (accept) begin
          if (frame_end) begin
            state_d  = SCAN;
            wr_cnt_d = '0;
          end else begin
            wr_cnt_d = wr_cnt_q + 1'b1;
          end
        end
      end

      SCAN: begin
        if (win_valid_q && WIN_READY && win_last_q) begin
          win_valid_d  = 1'b0;
          win_last_d   = 1'b0;
          frame_done_d = 1'b1;
          state_d      = FIN;
        end else if (load_en && !scan_done_q) begin
          win_valid_d = 1'b1;
          win_x_d     = sx_q;
          win_y_d     = sy_q;
          win_data_d  = gather;
          win_last_d  = (sx_q == X_MAX) && (sy_q == Y_MAX);
          // X runs fastest; the scan stops, never wraps, after the final anchor.
          if (sx_q == X_MAX) begin
            sx_d = '0;
            if (sy_q == Y_MAX) scan_done_d = 1'b1;
            else               sy_d        = sy_q + 1'b1;
          end else begin
            sx_d = sx_q + 1'b1;
          end
        end
      end

      FIN: begin
        state_d     = LOAD;
        sx_d        = '0;
        sy_d        = '0;
        scan_done_d = 1'b0;
        wr_cnt_d    = '0;
      end

      default: state_d = LOAD;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q      <= LOAD;
      wr_cnt_q     <= '0;
      sx_q         <= '0;
      sy_q         <= '0;
      scan_done_q  <= 1'b0;
      win_valid_q  <= 1'b0;
      win_last_q   <= 1'b0;
      win_x_q      <= '0;
      win_y_q      <= '0;
      win_data_q   <= '0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_cnt_q     <= wr_cnt_d;
      sx_q         <= sx_d;
      sy_q         <= sy_d;
      scan_done_q  <= scan_done_d;
      win_valid_q  <= win_valid_d;
      win_last_q   <= win_last_d;
      win_x_q      <= win_x_d;
      win_y_q      <= win_y_d;
      win_data_q   <= win_data_d;
      frame_done_q <= frame_done_d;
      err_q        <= err_d;
    end
  end

  assign PIX_READY  = (state_q == LOAD);
  assign WIN_VALID  = win_valid_q;
  assign WIN_X      = win_x_q;
  assign WIN_Y      = win_y_q;
  assign WIN_DATA   = win_data_q;
  assign WIN_LAST   = win_last_q;
  assign FRAME_DONE = frame_done_q;
`ifdef FRAME_ERR_EN
  assign ERR        = err_q;
`endif

endmodule
